multicycle_control_unit: RTL and testbench

Main control FSM of the 16-bit multi-cycle processor. Sits directly downstream of the instruction register: consumes the 7-bit control (opcode) field the IR latches, and drives every write-enable and mux select in the datapath, including the IR's own write enable and the PC write enable. One instruction occupies 3–5 states plus memory wait cycles.

---
 rtl/cu_pkg.sv | 65 ++++++
 rtl/multicycle_control_unit_if.sv | 36 +++
 rtl/cu_output_decode.sv | 73 +++++++
 rtl/multicycle_control_unit.sv | 93 +++++++++
 tb/tb_multicycle_control_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, state encoding,
// datapath mux selects and the control bundle driven into the datapath.
package cu_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_HALT   = 7'h7F;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_LUI_WB    = 4'd11,
    S_HALT      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_e;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] M2R_IMM    = 2'b11;

  localparam logic [1:0] ASB_REGB = 2'b00;
  localparam logic [1:0] ASB_ONE  = 2'b01;
  localparam logic [1:0] ASB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_REGA   = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle. master = control unit, slave = datapath.
interface multicycle_control_unit_if #(parameter int OPCODE_W = 7);
  logic [OPCODE_W-1:0] input_CU_Opcode;
  logic                input_CU_Zero;
  logic                input_CU_MemReady;
  logic                Output_CU_IRWrite;
  logic                Output_CU_PCWrite;
  logic                Output_CU_IorD;
  logic                Output_CU_MemRead;
  logic                Output_CU_MemWrite;
  logic                Output_CU_RegWrite;
  logic [1:0]          Output_CU_MemtoReg;
  logic                Output_CU_ALUSrcA;
  logic [1:0]          Output_CU_ALUSrcB;
  logic [1:0]          Output_CU_ALUOp;
  logic [1:0]          Output_CU_PCSource;
  logic                Output_CU_Halted;
  logic                Output_CU_Illegal;
  logic [3:0]          Output_CU_State;

  modport master (
    input  input_CU_Opcode, input_CU_Zero, input_CU_MemReady,
    output Output_CU_IRWrite, Output_CU_PCWrite, Output_CU_IorD, Output_CU_MemRead,
           Output_CU_MemWrite, Output_CU_RegWrite, Output_CU_MemtoReg, Output_CU_ALUSrcA,
           Output_CU_ALUSrcB, Output_CU_ALUOp, Output_CU_PCSource, Output_CU_Halted,
           Output_CU_Illegal, Output_CU_State
  );

  modport slave (
    output input_CU_Opcode, input_CU_Zero, input_CU_MemReady,
    input  Output_CU_IRWrite, Output_CU_PCWrite, Output_CU_IorD, Output_CU_MemRead,
           Output_CU_MemWrite, Output_CU_RegWrite, Output_CU_MemtoReg, Output_CU_ALUSrcA,
           Output_CU_ALUSrcB, Output_CU_ALUOp, Output_CU_PCSource, Output_CU_Halted,
           Output_CU_Illegal, Output_CU_State
  );
endinterface

// File: rtl/cu_output_decode.sv
// Combinational map from FSM state (plus opcode/Zero/MemReady) to datapath controls.
module cu_output_decode
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  state_e              state,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        // PC+1 is written back as the IR loads, so both enables track MemReady
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ASB_ONE;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE:   ctrl.alu_src_b = ASB_IMM;
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      S_ALU_WB:   ctrl.reg_write = 1'b1;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ASB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_source = PCS_ALUOUT;
        ctrl.pc_write  = zero;
      end
      S_JUMP: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = (opcode == OP_JALR) ? PCS_REGA : PCS_ALUOUT;
      end
      S_LUI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_IMM;
      end
      S_HALT:    ctrl.halted  = 1'b1;
      S_ILLEGAL: ctrl.illegal = 1'b1;
      default:   ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM of the 16-bit multi-cycle CPU. Optional perf counters are
// enabled by defining CU_PERF_COUNTERS_EN.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 7
) (
  input  logic CLK,
  input  logic RST_n,
  multicycle_control_unit_if.master cu
`ifdef CU_PERF_COUNTERS_EN
  ,
  output logic [31:0] Output_CU_CycleCount,
  output logic [31:0] Output_CU_InstrCount
`endif
);

  state_e state;
  ctrl_t  ctrl;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  if (cu.input_CU_MemReady) state <= S_DECODE;
        S_DECODE: begin
          case (cu.input_CU_Opcode)
            OP_RTYPE:          state <= S_EXEC_R;
            OP_ITYPE:          state <= S_EXEC_I;
            OP_LOAD, OP_STORE: state <= S_MEM_ADDR;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL, OP_JALR:   state <= S_JUMP;
            OP_LUI:            state <= S_LUI_WB;
            OP_HALT:           state <= S_HALT;
            default:           state <= S_ILLEGAL;
          endcase
        end
        S_EXEC_R, S_EXEC_I: state <= S_ALU_WB;
        // IR is stable until the next fetch, so LOAD/STORE can be re-read here
        S_MEM_ADDR:  state <= (cu.input_CU_Opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (cu.input_CU_MemReady) state <= S_MEM_WB;
        S_MEM_WRITE: if (cu.input_CU_MemReady) state <= S_FETCH;
        S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_LUI_WB: state <= S_FETCH;
        default: state <= state;
      endcase
    end
  end

  cu_output_decode #(.OPCODE_W(OPCODE_W)) u_dec (
    .state     (state),
    .opcode    (cu.input_CU_Opcode),
    .zero      (cu.input_CU_Zero),
    .mem_ready (cu.input_CU_MemReady),
    .ctrl      (ctrl)
  );

  // Fetch-side enables must not fire while reset is held
  assign cu.Output_CU_IRWrite  = ctrl.ir_write & RST_n;
  assign cu.Output_CU_PCWrite  = ctrl.pc_write & RST_n;
  assign cu.Output_CU_IorD     = ctrl.iord;
  assign cu.Output_CU_MemRead  = ctrl.mem_read;
  assign cu.Output_CU_MemWrite = ctrl.mem_write;
  assign cu.Output_CU_RegWrite = ctrl.reg_write;
  assign cu.Output_CU_MemtoReg = ctrl.mem_to_reg;
  assign cu.Output_CU_ALUSrcA  = ctrl.alu_src_a;
  assign cu.Output_CU_ALUSrcB  = ctrl.alu_src_b;
  assign cu.Output_CU_ALUOp    = ctrl.alu_op;
  assign cu.Output_CU_PCSource = ctrl.pc_source;
  assign cu.Output_CU_Halted   = ctrl.halted;
  assign cu.Output_CU_Illegal  = ctrl.illegal;
  assign cu.Output_CU_State    = state;

`ifdef CU_PERF_COUNTERS_EN
  logic frozen;
  logic instr_done;

  assign frozen     = (state == S_HALT) || (state == S_ILLEGAL);
  assign instr_done = (state inside {S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_LUI_WB}) ||
                      ((state == S_MEM_WRITE) && cu.input_CU_MemReady);

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      Output_CU_CycleCount <= '0;
      Output_CU_InstrCount <= '0;
    end else if (!frozen) begin
      Output_CU_CycleCount <= Output_CU_CycleCount + 32'd1;
      if (instr_done) Output_CU_InstrCount <= Output_CU_InstrCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: driver walks instruction step lists and queues expected
// per-cycle controls; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

  localparam logic [6:0] RTYPE = 7'h33, ITYPE = 7'h13, LOAD = 7'h03, STORE = 7'h23,
                         BRANCH = 7'h63, JAL = 7'h6F, JALR = 7'h67, LUI = 7'h37, HALT = 7'h7F;

  typedef struct packed {
    logic       irw, pcw, iord, mrd, mwr, rw;
    logic [1:0] m2r;
    logic       asa;
    logic [1:0] asb, aop, pcs;
    logic       halt, ill;
    logic [3:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  exp_t  exp_q[$];
  string name_q[$];

  multicycle_control_unit_if #(.OPCODE_W(7)) ifc ();

`ifdef CU_PERF_COUNTERS_EN
  logic [31:0] cyc_cnt, ins_cnt;
`endif

  multicycle_control_unit #(.OPCODE_W(7)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .cu    (ifc)
`ifdef CU_PERF_COUNTERS_EN
    ,
    .Output_CU_CycleCount (cyc_cnt),
    .Output_CU_InstrCount (ins_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected controls for one named step of an instruction
  function automatic exp_t ex(input string s, input logic mr, input logic z, input logic [6:0] op);
    exp_t e = '0;
    if (s == "FETCH") begin
      e.st = 4'd0; e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr;
    end else if (s == "DECODE") begin
      e.st = 4'd1; e.asb = 2'b10;
    end else if (s == "EXEC_R") begin
      e.st = 4'd2; e.asa = 1; e.aop = 2'b10;
    end else if (s == "EXEC_I") begin
      e.st = 4'd3; e.asa = 1; e.asb = 2'b10; e.aop = 2'b10;
    end else if (s == "ALU_WB") begin
      e.st = 4'd4; e.rw = 1;
    end else if (s == "MEM_ADDR") begin
      e.st = 4'd5; e.asa = 1; e.asb = 2'b10;
    end else if (s == "MEM_READ") begin
      e.st = 4'd6; e.mrd = 1; e.iord = 1;
    end else if (s == "MEM_WB") begin
      e.st = 4'd7; e.rw = 1; e.m2r = 2'b01;
    end else if (s == "MEM_WRITE") begin
      e.st = 4'd8; e.mwr = 1; e.iord = 1;
    end else if (s == "BRANCH") begin
      e.st = 4'd9; e.asa = 1; e.aop = 2'b01; e.pcs = 2'b01; e.pcw = z;
    end else if (s == "JUMP") begin
      e.st = 4'd10; e.rw = 1; e.m2r = 2'b10; e.pcw = 1; e.pcs = (op == JALR) ? 2'b10 : 2'b01;
    end else if (s == "LUI_WB") begin
      e.st = 4'd11; e.rw = 1; e.m2r = 2'b11;
    end else if (s == "HALT") begin
      e.st = 4'd12; e.halt = 1;
    end else begin
      e.st = 4'd13; e.ill = 1;
    end
    return e;
  endfunction

  task automatic step(input string s, input logic mr, input logic z, input logic [6:0] op);
    ifc.input_CU_MemReady = mr;
    ifc.input_CU_Zero     = z;
    ifc.input_CU_Opcode   = op;
    exp_q.push_back(ex(s, mr & rst_n, z, op));
    name_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: fw fetch-wait cycles, mw memory-wait cycles, bz = Zero in BRANCH
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic bz);
    for (int i = 0; i < fw; i++) step("FETCH", 1'b0, rb(), 7'($urandom));
    step("FETCH", 1'b1, rb(), op);
    step("DECODE", rb(), rb(), op);
    case (op)
      RTYPE: begin step("EXEC_R", rb(), rb(), op); step("ALU_WB", rb(), rb(), op); end
      ITYPE: begin step("EXEC_I", rb(), rb(), op); step("ALU_WB", rb(), rb(), op); end
      LOAD: begin
        step("MEM_ADDR", rb(), rb(), op);
        for (int i = 0; i < mw; i++) step("MEM_READ", 1'b0, rb(), op);
        step("MEM_READ", 1'b1, rb(), op);
        step("MEM_WB", rb(), rb(), op);
      end
      STORE: begin
        step("MEM_ADDR", rb(), rb(), op);
        for (int i = 0; i < mw; i++) step("MEM_WRITE", 1'b0, rb(), op);
        step("MEM_WRITE", 1'b1, rb(), op);
      end
      BRANCH:    step("BRANCH", rb(), bz, op);
      JAL, JALR: step("JUMP", rb(), rb(), op);
      LUI:       step("LUI_WB", rb(), rb(), op);
      HALT:      for (int i = 0; i < 3; i++) step("HALT", rb(), rb(), op);
      default:   for (int i = 0; i < 3; i++) step("ILLEGAL", rb(), rb(), op);
    endcase
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", n, act, req);
    end
  endtask

  // Monitor
  initial begin
    exp_t a, e;
    string n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        a.irw = ifc.Output_CU_IRWrite;  a.pcw = ifc.Output_CU_PCWrite;
        a.iord = ifc.Output_CU_IorD;    a.mrd = ifc.Output_CU_MemRead;
        a.mwr = ifc.Output_CU_MemWrite; a.rw = ifc.Output_CU_RegWrite;
        a.m2r = ifc.Output_CU_MemtoReg; a.asa = ifc.Output_CU_ALUSrcA;
        a.asb = ifc.Output_CU_ALUSrcB;  a.aop = ifc.Output_CU_ALUOp;
        a.pcs = ifc.Output_CU_PCSource; a.halt = ifc.Output_CU_Halted;
        a.ill = ifc.Output_CU_Illegal;  a.st = ifc.Output_CU_State;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s: got %h want %h", n, a, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [6:0] ops[8] = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI};
    ifc.input_CU_Opcode = RTYPE; ifc.input_CU_Zero = 1'b0; ifc.input_CU_MemReady = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    step("FETCH", 1'b1, 1'b0, RTYPE);
    step("FETCH", 1'b1, 1'b0, RTYPE);
    rst_n = 1'b1;

    run_instr(RTYPE, 0, 0, 1'b0);
    run_instr(LOAD, 0, 3, 1'b0);
    run_instr(BRANCH, 0, 0, 1'b1);
    run_instr(BRANCH, 0, 0, 1'b0);
    run_instr(JALR, 0, 0, 1'b0);
    run_instr(JAL, 1, 0, 1'b0);

    for (int k = 0; k < 40; k++)
      run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3), rb());

    // Reset in the middle of a stalled store
    step("FETCH", 1'b1, rb(), STORE);
    step("DECODE", 1'b1, rb(), STORE);
    step("MEM_ADDR", 1'b1, rb(), STORE);
    step("MEM_WRITE", 1'b0, rb(), STORE);
    rst_n = 1'b0;
    step("MEM_WRITE", 1'b0, rb(), STORE);
    step("FETCH", 1'b1, rb(), STORE);
    rst_n = 1'b1;

    run_instr(7'h55, 0, 0, 1'b0);
    rst_n = 1'b0;
    step("ILLEGAL", 1'b1, rb(), 7'h55);
    step("FETCH", 1'b1, rb(), 7'h55);
    rst_n = 1'b1;

    run_instr(RTYPE, 0, 0, 1'b0);
    run_instr(STORE, 0, 0, 1'b0);
    step("FETCH", 1'b1, rb(), HALT);
    step("DECODE", 1'b1, rb(), HALT);
`ifdef CU_PERF_COUNTERS_EN
    chk("cycle_count_at_halt", cyc_cnt, 32'd10);
    chk("instr_count_at_halt", ins_cnt, 32'd2);
`endif
    step("HALT", 1'b1, rb(), HALT);
    step("HALT", 1'b0, rb(), 7'h55);
    step("HALT", 1'b1, rb(), RTYPE);
`ifdef CU_PERF_COUNTERS_EN
    chk("cycle_count_frozen", cyc_cnt, 32'd10);
    chk("instr_count_frozen", ins_cnt, 32'd2);
`endif

    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
